// File: rtl/axil_elastic_buffer.sv
// Elastic buffer for one AXI-lite channel: circular store plus optional output register.
// in_ready depends only on registered state and flush, never on out_ready.
module axil_elastic_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 2,
  parameter int REGISTER_OUTPUT   = 1,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
  localparam int CAPACITY         = DEPTH + REGISTER_OUTPUT,
  localparam int OCC_W            = $clog2(CAPACITY + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] CAP_OCC = OCC_W'(CAPACITY);
  localparam logic [OCC_W-1:0] AF_OCC  = OCC_W'(ALMOST_FULL_LEVEL);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;
  logic                  af_q;
  logic                  rdy_en_q;

  logic                  push, pop, st_empty, load, bypass, st_write, st_read;
  logic [DATA_WIDTH-1:0] rd_data;

  assign st_empty = (rd_ptr_q == wr_ptr_q);
  assign rd_data  = mem[rd_ptr_q[AW-1:0]];

  assign in_ready  = rdy_en_q && (occ_q != CAP_OCC) && !flush;
  assign out_valid = (REGISTER_OUTPUT != 0) ? ov_q : !st_empty;
  // Without an output register od_q holds the last word read, shown while storage is empty.
  assign out_data  = ((REGISTER_OUTPUT != 0) || st_empty) ? od_q : rd_data;
  assign occupancy   = occ_q;
  assign almost_full = af_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Output register refills when empty or being drained; an empty store lets the input fall through.
  assign load     = (REGISTER_OUTPUT != 0) && (!ov_q || pop);
  assign bypass   = load && st_empty && push;
  assign st_write = push && !bypass;
  assign st_read  = (REGISTER_OUTPUT != 0) ? (load && !st_empty) : pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ov_d     = ov_q;
    od_d     = od_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      ov_d     = 1'b0;
    end else begin
      if (st_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (st_read)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      occ_d = occ_q + OCC_ONE;
      else if (pop && !push) occ_d = occ_q - OCC_ONE;
      if (REGISTER_OUTPUT != 0) begin
        if (load) begin
          if (!st_empty) begin
            ov_d = 1'b1;
            od_d = rd_data;
          end else if (push) begin
            ov_d = 1'b1;
            od_d = in_data;
          end else begin
            ov_d = 1'b0;
          end
        end
      end else if (pop) begin
        od_d = rd_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      af_q     <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      af_q     <= (occ_d >= AF_OCC);
      rdy_en_q <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (st_write) mem[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_axil_elastic_buffer.sv
// Bench for axil_elastic_buffer: three configurations share one stimulus stream,
// each tracked by a queue model of ideal FIFO behaviour.
module tb_axil_elastic_buffer;

  localparam int ND = 3;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic [ND-1:0] irdy, ov, af;
  logic [31:0]   od0, od1, od2;
  logic [2:0]    occ_a;
  logic [1:0]    occ_b;
  logic [3:0]    occ_c;

  always #5 clock = ~clock;

  axil_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .REGISTER_OUTPUT(1)) u_d4r1 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
    .occupancy(occ_a), .almost_full(af[0]));

  axil_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(2), .REGISTER_OUTPUT(0)) u_d2r0 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ_b), .almost_full(af[1]));

  axil_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(8), .REGISTER_OUTPUT(1)) u_d8r1 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2),
    .occupancy(occ_c), .almost_full(af[2]));

  // Reference model: one circular queue per configuration.
  logic [31:0] mq [ND][16];
  int          head [ND];
  int          cnt  [ND];
  int          nacc [ND];
  int          ovcnt [ND];
  logic        acc  [ND];
  logic        rdy_m;
  int          errors = 0;
  int          checks = 0;

  function automatic int cap_of(input int d);
    case (d)
      0:       return 5;
      1:       return 2;
      default: return 9;
    endcase
  endfunction

  function automatic int afl_of(input int d);
    case (d)
      0:       return 3;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic logic [31:0] dout(input int d);
    case (d)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  function automatic logic [31:0] occ_of(input int d);
    case (d)
      0:       return 32'(occ_a);
      1:       return 32'(occ_b);
      default: return 32'(occ_c);
    endcase
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      head[d] = 0;
      cnt[d]  = 0;
      acc[d]  = 1'b0;
    end
    rdy_m = 1'b0;
  endtask

  // Applies one clock edge to the model using the inputs presented before the edge.
  task automatic model_update();
    if (reset) begin
      model_reset();
    end else begin
      for (int d = 0; d < ND; d++) begin
        logic p, o;
        p = in_valid && rdy_m && !flush && (cnt[d] < cap_of(d));
        o = (cnt[d] > 0) && out_ready;
        acc[d] = p;
        if (flush) begin
          head[d] = 0;
          cnt[d]  = 0;
        end else begin
          if (o) begin
            head[d] = (head[d] + 1) % 16;
            cnt[d]--;
          end
          if (p) begin
            mq[d][(head[d] + cnt[d]) % 16] = in_data;
            cnt[d]++;
            nacc[d]++;
          end
        end
      end
      rdy_m = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_in_ready"}, d, 32'(irdy[d]), 32'd0);
      chk({tag, "_out_valid"}, d, 32'(ov[d]), 32'd0);
      chk({tag, "_out_data"}, d, dout(d), 32'd0);
      chk({tag, "_occupancy"}, d, occ_of(d), 32'd0);
      chk({tag, "_almost_full"}, d, 32'(af[d]), 32'd0);
    end
  endtask

  // Monitor: compares every output against the model away from the active edge.
  initial begin
    logic [31:0] pdata  [ND];
    logic        pstall [ND];
    for (int d = 0; d < ND; d++) begin
      pdata[d]  = '0;
      pstall[d] = 1'b0;
      ovcnt[d]  = 0;
    end
    forever begin
      @(negedge clock);
      for (int d = 0; d < ND; d++) begin
        chk("occupancy", d, occ_of(d), 32'(cnt[d]));
        chk("out_valid", d, 32'(ov[d]), 32'(cnt[d] > 0));
        chk("in_ready", d, 32'(irdy[d]), 32'(rdy_m && !flush && (cnt[d] < cap_of(d))));
        chk("almost_full", d, 32'(af[d]), 32'(cnt[d] >= afl_of(d)));
        if (cnt[d] > 0) chk("out_data", d, dout(d), mq[d][head[d]]);
        if (pstall[d] && !reset) begin
          chk("stall_valid", d, 32'(ov[d]), 32'd1);
          chk("stall_data", d, dout(d), pdata[d]);
        end
        pstall[d] = ov[d] && !out_ready && !flush && !reset;
        pdata[d]  = dout(d);
        if (ov[d]) ovcnt[d]++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_acc [ND];
    int s_ov  [ND];
    for (int d = 0; d < ND; d++) nacc[d] = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    step();
    step();
    chk_reset_outputs("reset");

    // Release between edges; in_ready rises on the first edge afterwards.
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) chk("in_ready_pre_edge", d, 32'(irdy[d]), 32'd0);
    step();
    for (int d = 0; d < ND; d++) chk("in_ready_first_edge", d, 32'(irdy[d]), 32'd1);

    // Streaming 1..16 with out_ready held high.
    out_ready = 1'b1;
    for (int d = 0; d < ND; d++) begin s_acc[d] = nacc[d]; s_ov[d] = ovcnt[d]; end
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'(i + 1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    for (int d = 0; d < ND; d++) begin
      chk("stream_accepts", d, 32'(nacc[d] - s_acc[d]), 32'd16);
      chk("stream_valid_cycles", d, 32'(ovcnt[d] - s_ov[d]), 32'd16);
    end

    // Back-pressure: offer 0xA0.. with out_ready low.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA0;
    s_acc[0] = nacc[0];
    repeat (8) begin step(); if (acc[0]) in_data++; end
    chk("bp_accepts", 0, 32'(nacc[0] - s_acc[0]), 32'd5);
    chk("bp_occupancy", 0, occ_of(0), 32'd5);
    chk("bp_head", 0, od0, 32'hA0);
    chk("bp_almost_full", 0, 32'(af[0]), 32'd1);
    chk("bp_in_ready", 0, 32'(irdy[0]), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && in_data <= 32'hA7; i++) begin step(); if (acc[0]) in_data++; end
    in_valid = 1'b0;
    repeat (12) step();

    // Full buffer with single-cycle pop pulses; many laps of the pointers.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1000;
    repeat (12) begin step(); if (acc[0]) in_data++; end
    for (int i = 0; i < 30; i++) begin
      out_ready = 1'b1;
      step(); if (acc[0]) in_data++;
      out_ready = 1'b0;
      for (int d = 0; d < ND; d++) chk("pulse_in_ready", d, 32'(irdy[d]), 32'd1);
      step(); if (acc[0]) in_data++;
      for (int d = 0; d < ND; d++) chk("pulse_refill_occ", d, occ_of(d), 32'(cap_of(d)));
      step(); if (acc[0]) in_data++;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (12) step();

    // Flush with a push and a pop presented in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h100;
    repeat (3) begin step(); if (acc[0]) in_data++; end
    chk("pre_flush_occ", 0, occ_of(0), 32'd3);
    flush = 1'b1; out_ready = 1'b1; in_data = 32'hDEAD;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk("flush_occ", d, occ_of(d), 32'd0);
      chk("flush_valid", d, 32'(ov[d]), 32'd0);
    end
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk("post_flush_valid", d, 32'(ov[d]), 32'd1);
      chk("post_flush_data", d, dout(d), 32'h55);
    end
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;

    // Asynchronous reset between edges with two words held.
    in_valid = 1'b1; in_data = 32'h200; step();
    in_data = 32'h201; step();
    in_valid = 1'b0;
    chk("pre_areset_occ", 0, occ_of(0), 32'd2);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clock);
    #1 reset = 1'b0;
    for (int d = 0; d < ND; d++) chk("areset_in_ready_low", d, 32'(irdy[d]), 32'd0);
    step();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h300;
    step();
    for (int d = 0; d < ND; d++) chk("restart_first_word", d, dout(d), 32'h300);
    for (int i = 1; i < 4; i++) begin in_data = 32'h300 + 32'(i); step(); end
    in_valid = 1'b0;
    repeat (4) step();

    // Random traffic with occasional flush.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = $urandom;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step();
    for (int d = 0; d < ND; d++) chk("final_empty", d, occ_of(d), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_elastic_buffer.md
# axil_elastic_buffer

- Parametrised elastic buffer for one AXI-lite channel (AW, W, B, AR or R): a small circular store of DEPTH entries plus an optional registered output stage.
- Breaks every combinational path between `out_ready` and `in_ready`.
- Sustains one transfer per clock in both directions; adds occupancy reporting, an almost-full flag and a synchronous flush.
- Used between AXI-lite interconnect stages and register-file slaves where a single skid slot is not enough to absorb bursty back-pressure.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥1)
- DEPTH, 2, storage entries; power of two, ≥2
- REGISTER_OUTPUT, 1, 1 = `out_data`/`out_valid` driven from flops; 0 = driven from the head of storage through a read mux
- ALMOST_FULL_LEVEL, DEPTH-1, occupancy at or above which `almost_full` asserts (1..CAPACITY)
- Derived: CAPACITY = DEPTH + REGISTER_OUTPUT; OCC_W = $clog2(CAPACITY+1)
- clock  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous clear; discards all stored words
- in_valid  in  1  upstream word valid
- in_ready  out  1  buffer can accept a word this cycle
- in_data  in  DATA_WIDTH  upstream payload
- out_valid  out  1  head word valid
- out_ready  in  1  downstream accepts head word
- out_data  out  DATA_WIDTH  head payload
- occupancy  out  OCC_W  number of words held (storage + output register)
- almost_full  out  1  occupancy ≥ ALMOST_FULL_LEVEL

## Operation
- Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Storage: DEPTH×DATA_WIDTH array.
  - Read/write pointers are $clog2(DEPTH) bits plus a wrap bit.
  - Full = pointers equal except the wrap bit; empty = all bits equal.
  - Pointers wrap DEPTH-1 → 0.
- `in_ready` = ready-enable flop AND NOT (occupancy == CAPACITY).
  - The term depends only on registered state, never on `out_ready` in the same cycle.
  - A pop when full raises `in_ready` one cycle later.
- REGISTER_OUTPUT=0:
  - `out_valid` = storage not empty; `out_data` = mem[rd_ptr].
  - When empty, `out_data` shows the last entry read.
- REGISTER_OUTPUT=1: output register (valid flop + data flop) fed from storage.
  - Register empty, or popping this cycle, with storage non-empty: load mem[rd_ptr] and advance rd_ptr.
  - Register empty, or popping, with storage empty and a push this cycle: fall through, loading `in_data` directly; no storage write.
  - Otherwise a push writes storage at wr_ptr.
- Simultaneous push and pop: occupancy unchanged; both pointers advance where applicable.
- Occupancy: +1 on push-only, −1 on pop-only, unchanged otherwise; never exceeds CAPACITY, never underflows.
- AXI stability: while `out_valid && !out_ready`, `out_data` and `out_valid` stay constant.
- flush (sampled at edge):
  - Occupancy → 0, pointers → 0, `out_valid` → 0.
  - `in_ready` forced low in the flush cycle, so no push is accepted.
  - A pop presented in the same cycle is discarded.
  - flush has priority over push and pop.
- reset (asynchronous, any time including mid-transfer):
  - Pointers 0, occupancy 0, `out_valid` 0, `out_data` 0, `almost_full` 0, ready-enable flop 0, so `in_ready` 0.
  - Storage contents are not cleared.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `occupancy`=0, `almost_full`=0.
- `in_ready` rises at the first rising edge after reset deasserts. Ready-enable flop: set to 1 on each edge, cleared asynchronously by reset.
- Latency from push at edge k to `out_valid` high, both modes: after edge k, i.e. visible in cycle k+1.
- Throughput: 1 word/cycle sustained when `out_ready` is held high, with zero bubbles in either mode.
- Back-pressure: with `out_ready` low, exactly CAPACITY words are accepted, then `in_ready` drops.
  - `in_ready` drops in the cycle after the push that fills the buffer.
- `occupancy` and `almost_full` are registered and update on the edge that performs the push, pop or flush.
- Order: strictly FIFO; no word is duplicated or dropped except by flush or reset.

## Test plan
- Reset, then stream 0x00000001..0x00000010 with `out_ready`=1 → `in_ready` high from edge 1 after reset; each word appears one cycle after acceptance, in order, 16 consecutive `out_valid` cycles.
- DEPTH=4, REGISTER_OUTPUT=1, `out_ready`=0, `in_valid`=1 with data 0xA0..0xA7 → exactly 5 words accepted (0xA0..0xA4); `occupancy`=5; `almost_full` high from occupancy 3; `out_data`=0xA0 held stable.
  - Then `out_ready`=1 → 0xA0..0xA4 drain in order, then 0xA5.. follow with no gap.
- Full buffer, with a single-cycle `out_ready` pulse and `in_valid` held → `in_ready` rises one cycle after the pop; occupancy returns to CAPACITY; pointers wrap correctly across ≥3 full laps (DEPTH=2 and DEPTH=8).
- Occupancy 3, then assert flush together with `in_valid`=1 and `out_ready`=1 → next cycle `occupancy`=0 and `out_valid`=0; neither the flush-cycle input word nor the popped word is observed downstream.
- Assert reset asynchronously mid-stream (between edges, occupancy 2) → all outputs go to reset values immediately without a clock edge; after deassertion the stream restarts cleanly with the first new word.
- Random `in_valid`/`out_ready` (50%) for 10k cycles, both REGISTER_OUTPUT values → scoreboard matches, `out_data` stable under stall, and `occupancy` equals pushes minus pops.
